// File: rtl/frame_generator_paced_if.sv
// AXI4-Stream link carrying generated test frames from the frame generator
// toward the MAC TX path.
//   data  : beat payload, DATA_WIDTH bits
//   keep  : byte enables, DATA_WIDTH/8 bits
//   last  : final beat of a frame
//   user  : per-byte sideband, DATA_WIDTH/8 bits
//   id    : stream id, ID_WIDTH bits
//   valid : beat presented by the master
//   ready : beat accepted by the slave
interface frame_generator_paced_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3
) ();
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic [DATA_WIDTH/8-1:0] user;
    logic [ID_WIDTH-1:0]     id;
    logic                    valid;
    logic                    ready;

    modport master (
        output data, keep, last, user, id, valid,
        input  ready
    );

    modport slave (
        input  data, keep, last, user, id, valid,
        output ready
    );
endinterface

// File: rtl/frame_generator_paced.sv
// Paced Ethernet/IPv4 test-frame generator, one instance per tester port.
// Emits frames with a fixed header (TEST_FRAME_TOS / TEST_FRAME_PROTO, valid
// IPv4 header checksum) followed by a repeated 16-bit LFSR payload, with an
// optional frame-count limit, inter-frame gap and frame-size sweep.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a run (honoured only in IDLE with port_config.enable)
//   stop         : end the run at the next frame boundary
//   port_config  : MACs, IPs, base frame size, enable
//   frame_count  : frames per run, 0 = unlimited
//   gap_cycles   : idle cycles after every frame
//   sweep_en     : step the frame size each frame
//   size_step    : sweep increment in bytes
//   size_max     : sweep upper bound in bytes
//   ready        : generator idle
//   done         : one-cycle pulse when a run ends
//   sent_frames  : frames completed in the current/last run
//   sent_bytes   : bytes completed in the current/last run
//   axis_m       : AXI4-Stream master toward the MAC

package frame_generator_paced_pkg;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] frame_size;
        logic        enable;
    } port_config_t;

    // Wire-order header; the IPv4 part occupies the low 160 bits.
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] ip_id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } frame_header_t;

    localparam logic [7:0]  TEST_FRAME_TOS   = 8'h28;
    localparam logic [7:0]  TEST_FRAME_PROTO = 8'hFD;
    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL       = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF      = 16'h4000;
    localparam logic [7:0]  IP_TTL           = 8'h40;
    localparam logic [15:0] ID_SEED          = 16'h1D0F;
    localparam logic [15:0] PAYLOAD_SEED     = 16'hACE1;
    localparam logic [15:0] MIN_FRAME_BYTES  = 16'd60;
    localparam logic [15:0] ETH_HDR_BYTES    = 16'd14;

    // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One's-complement checksum over the IPv4 header words.
    function automatic logic [15:0] ip_checksum(input frame_header_t h);
        logic [31:0] s;
        s = {16'h0000, h.ver_ihl, h.tos}
          + {16'h0000, h.total_len}
          + {16'h0000, h.ip_id}
          + {16'h0000, h.flags_frag}
          + {16'h0000, h.ttl, h.proto}
          + {16'h0000, h.checksum}
          + {16'h0000, h.src_ip[31:16]}
          + {16'h0000, h.src_ip[15:0]}
          + {16'h0000, h.dst_ip[31:16]}
          + {16'h0000, h.dst_ip[15:0]};
        s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic logic [15:0] clamp_size(input logic [15:0] s);
        return (s < MIN_FRAME_BYTES) ? MIN_FRAME_BYTES : s;
    endfunction

endpackage

module frame_generator_paced
    import frame_generator_paced_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  port_config_t          port_config,
    input  logic [CNT_WIDTH-1:0]  frame_count,
    input  logic [15:0]           gap_cycles,
    input  logic                  sweep_en,
    input  logic [15:0]           size_step,
    input  logic [15:0]           size_max,
    output logic                  ready,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sent_frames,
    output logic [CNT_WIDTH-1:0]  sent_bytes,
    frame_generator_paced_if.master axis_m
);

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int HDR_W = $bits(frame_header_t);
    localparam int NREP  = DATA_WIDTH / 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t state_r, state_nx;

    // Run parameters latched at start
    logic [47:0]          dst_mac_r, src_mac_r;
    logic [31:0]          src_ip_r, dst_ip_r;
    logic [CNT_WIDTH-1:0] cnt_lim_r;
    logic [15:0]          gap_lim_r;
    logic                 sweep_r;
    logic [15:0]          step_r, min_r, max_r;

    // Per-frame / per-beat state
    logic [15:0] size_r, size_nx;
    logic [15:0] remain_r, remain_nx;
    logic [15:0] pay_r, pay_nx;
    logic        first_r, first_nx;
    logic [15:0] gap_cnt_r, gap_cnt_nx;
    logic        stop_pend_r, stop_pend_nx;
    logic [15:0] id_r, id_nx;

    logic [CNT_WIDTH-1:0] sent_frames_r, sent_bytes_r;

    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [BPB-1:0]        keep_r, keep_s;
    logic                  last_r, last_s;
    logic                  valid_r, done_r, ready_r;

    logic        fire_s, last_fire_s, start_go_s, stop_now_s, limit_hit_s;
    logic [15:0] start_min_s, next_sz_s;

    assign fire_s      = valid_r & axis_m.ready;
    assign last_fire_s = fire_s & last_r;
    assign start_go_s  = (state_r == ST_IDLE) & start & port_config.enable;
    assign stop_now_s  = stop_pend_r | stop;
    assign start_min_s = clamp_size(port_config.frame_size);
    assign limit_hit_s = (cnt_lim_r != {CNT_WIDTH{1'b0}}) &&
                         ((sent_frames_r + CNT_WIDTH'(1)) == cnt_lim_r);
    assign id_nx       = last_fire_s ? lfsr16_next(id_r) : id_r;

    // Size of the frame after the current one; an inverted sweep range
    // degenerates to a fixed size.
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, size_r} + {1'b0, step_r};
        if (!sweep_r || (max_r < min_r)) begin
            next_sz_s = size_r;
        end else if (sum > {1'b0, max_r}) begin
            next_sz_s = min_r;
        end else begin
            next_sz_s = sum[15:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            size_r      <= 16'd0;
            remain_r    <= 16'd0;
            pay_r       <= 16'd0;
            first_r     <= 1'b0;
            gap_cnt_r   <= 16'd0;
            stop_pend_r <= 1'b0;
            id_r        <= ID_SEED;
        end else begin
            state_r     <= state_nx;
            size_r      <= size_nx;
            remain_r    <= remain_nx;
            pay_r       <= pay_nx;
            first_r     <= first_nx;
            gap_cnt_r   <= gap_cnt_nx;
            stop_pend_r <= stop_pend_nx;
            id_r        <= id_nx;
        end
    end

    // Next-state and per-beat bookkeeping
    always_comb begin
        state_nx     = state_r;
        size_nx      = size_r;
        remain_nx    = remain_r;
        pay_nx       = pay_r;
        first_nx     = first_r;
        gap_cnt_nx   = gap_cnt_r;
        stop_pend_nx = stop_pend_r;
        case (state_r)
            ST_IDLE: begin
                stop_pend_nx = 1'b0;
                if (start_go_s) begin
                    state_nx  = ST_SEND;
                    size_nx   = start_min_s;
                    remain_nx = start_min_s;
                    pay_nx    = PAYLOAD_SEED;
                    first_nx  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SEND: begin
                stop_pend_nx = stop_now_s;
                if (last_fire_s) begin
                    size_nx = next_sz_s;
                    if (stop_now_s || limit_hit_s) begin
                        state_nx     = ST_IDLE;
                        stop_pend_nx = 1'b0;
                    end else if (gap_lim_r != 16'd0) begin
                        state_nx   = ST_GAP;
                        gap_cnt_nx = 16'd0;
                    end else begin
                        // Back-to-back: next frame's beat 0 goes out next cycle
                        remain_nx = next_sz_s;
                        pay_nx    = PAYLOAD_SEED;
                        first_nx  = 1'b1;
                    end
                end else if (fire_s) begin
                    remain_nx = remain_r - 16'(BPB);
                    pay_nx    = lfsr16_next(pay_r);
                    first_nx  = 1'b0;
                end else begin
                    state_nx = ST_SEND;
                end
            end
            ST_GAP: begin
                stop_pend_nx = stop_now_s;
                if (stop_now_s) begin
                    state_nx     = ST_IDLE;
                    stop_pend_nx = 1'b0;
                end else if (gap_cnt_r == (gap_lim_r - 16'd1)) begin
                    state_nx  = ST_SEND;
                    remain_nx = size_r;
                    pay_nx    = PAYLOAD_SEED;
                    first_nx  = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt_r + 16'd1;
                end
            end
            default: begin
                state_nx     = ST_IDLE;
                stop_pend_nx = 1'b0;
            end
        endcase
    end

    // Beat contents for the next cycle; while stalled every input here is
    // unchanged, so the registered beat holds steady by construction.
    always_comb begin
        frame_header_t hdr;
        hdr            = '0;
        hdr.dst_mac    = start_go_s ? port_config.dst_mac : dst_mac_r;
        hdr.src_mac    = start_go_s ? port_config.src_mac : src_mac_r;
        hdr.ethertype  = ETHERTYPE_IPV4;
        hdr.ver_ihl    = IP_VER_IHL;
        hdr.tos        = TEST_FRAME_TOS;
        hdr.total_len  = size_nx - ETH_HDR_BYTES;
        hdr.ip_id      = id_nx;
        hdr.flags_frag = IP_FLAGS_DF;
        hdr.ttl        = IP_TTL;
        hdr.proto      = TEST_FRAME_PROTO;
        hdr.src_ip     = start_go_s ? port_config.src_ip : src_ip_r;
        hdr.dst_ip     = start_go_s ? port_config.dst_ip : dst_ip_r;
        hdr.checksum   = ip_checksum(hdr);

        data_s = {NREP{pay_nx}};
        if (first_nx) begin
            data_s[HDR_W-1:0] = hdr;
        end else begin
            data_s = {NREP{pay_nx}};
        end
        for (int i = 0; i < BPB; i++) begin
            keep_s[i] = (16'(i) < remain_nx);
        end
        last_s = (remain_nx <= 16'(BPB));

        if (state_nx != ST_SEND) begin
            data_s = {DATA_WIDTH{1'b0}};
            keep_s = {BPB{1'b0}};
            last_s = 1'b0;
        end else begin
            last_s = last_s;
        end
    end

    // Registered AXIS outputs and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            keep_r  <= {BPB{1'b0}};
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            valid_r <= (state_nx == ST_SEND);
            data_r  <= data_s;
            keep_r  <= keep_s;
            last_r  <= last_s;
            done_r  <= (state_r != ST_IDLE) && (state_nx == ST_IDLE);
            ready_r <= (state_nx == ST_IDLE);
        end
    end

    // Run configuration latch and completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_mac_r     <= 48'd0;
            src_mac_r     <= 48'd0;
            src_ip_r      <= 32'd0;
            dst_ip_r      <= 32'd0;
            cnt_lim_r     <= {CNT_WIDTH{1'b0}};
            gap_lim_r     <= 16'd0;
            sweep_r       <= 1'b0;
            step_r        <= 16'd0;
            min_r         <= 16'd0;
            max_r         <= 16'd0;
            sent_frames_r <= {CNT_WIDTH{1'b0}};
            sent_bytes_r  <= {CNT_WIDTH{1'b0}};
        end else if (start_go_s) begin
            dst_mac_r     <= port_config.dst_mac;
            src_mac_r     <= port_config.src_mac;
            src_ip_r      <= port_config.src_ip;
            dst_ip_r      <= port_config.dst_ip;
            cnt_lim_r     <= frame_count;
            gap_lim_r     <= gap_cycles;
            sweep_r       <= sweep_en;
            step_r        <= size_step;
            min_r         <= start_min_s;
            max_r         <= clamp_size(size_max);
            sent_frames_r <= {CNT_WIDTH{1'b0}};
            sent_bytes_r  <= {CNT_WIDTH{1'b0}};
        end else if (last_fire_s) begin
            sent_frames_r <= sent_frames_r + CNT_WIDTH'(1);
            sent_bytes_r  <= sent_bytes_r + CNT_WIDTH'(size_r);
        end else begin
            sent_frames_r <= sent_frames_r;
        end
    end

    assign ready        = ready_r;
    assign done         = done_r;
    assign sent_frames  = sent_frames_r;
    assign sent_bytes   = sent_bytes_r;
    assign axis_m.data  = data_r;
    assign axis_m.keep  = keep_r;
    assign axis_m.last  = last_r;
    assign axis_m.user  = {BPB{1'b0}};
    assign axis_m.id    = {ID_WIDTH{1'b0}};
    assign axis_m.valid = valid_r;

endmodule

// File: tb/tb_frame_generator_paced.sv
// Self-checking bench for frame_generator_paced (DATA_WIDTH 512, 64 bytes per beat).
module tb_frame_generator_paced;
    import frame_generator_paced_pkg::*;

    localparam int DW  = 512;
    localparam int BPB = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start, stop, sweep_en;
    port_config_t port_config;
    logic [31:0] frame_count;
    logic [15:0] gap_cycles, size_step, size_max;
    logic ready, done;
    logic [31:0] sent_frames, sent_bytes;

    frame_generator_paced_if #(.DATA_WIDTH(DW), .ID_WIDTH(3)) axis ();

    frame_generator_paced #(.DATA_WIDTH(DW), .ID_WIDTH(3), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .port_config(port_config), .frame_count(frame_count),
        .gap_cycles(gap_cycles), .sweep_en(sweep_en), .size_step(size_step),
        .size_max(size_max), .ready(ready), .done(done),
        .sent_frames(sent_frames), .sent_bytes(sent_bytes), .axis_m(axis)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         first;
    } beat_t;

    beat_t q[$];
    logic [15:0] m_id, m_size, m_min, m_max, m_step;
    logic        m_sweep;
    int          frames_run;

    function automatic logic [15:0] tb_lfsr(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [15:0] fold_sum(input logic [159:0] ip);
        int s = 0;
        for (int i = 0; i < 10; i++) s += int'(ip[16*i +: 16]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
        return 16'(s);
    endfunction

    task automatic gen_frame();
        int sz, nb, rem;
        logic [15:0] pay, len;
        logic [271:0] hdr;
        beat_t b;
        sz  = int'(m_size);
        nb  = (sz + BPB - 1) / BPB;
        len = m_size - 16'd14;
        hdr = {port_config.dst_mac, port_config.src_mac, 16'h0800, 8'h45, TEST_FRAME_TOS,
               len, m_id, 16'h4000, 8'h40, TEST_FRAME_PROTO, 16'h0000,
               port_config.src_ip, port_config.dst_ip};
        hdr[79:64] = ~fold_sum(hdr[159:0]);
        pay = PAYLOAD_SEED;
        for (int k = 0; k < nb; k++) begin
            b.data = {32{pay}};
            if (k == 0) b.data[271:0] = hdr;
            rem    = sz - BPB * k;
            b.keep = (rem >= BPB) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << rem) - 64'd1);
            b.last = (k == nb - 1);
            b.first = (k == 0);
            q.push_back(b);
            pay = tb_lfsr(pay);
        end
        m_id = tb_lfsr(m_id);
        if (m_sweep && (m_max >= m_min)) begin
            if ({1'b0, m_size} + {1'b0, m_step} > {1'b0, m_max}) m_size = m_min;
            else m_size = m_size + m_step;
        end
    endtask

    // ---------------- compare process ----------------
    logic         bp_en = 1'b0;
    logic         prev_stall = 1'b0, prev_done = 1'b0, after_last = 1'b0;
    logic [511:0] pd;
    logic [63:0]  pk;
    logic         pl;
    int           gapcnt = 0, last_gap = -1;
    logic [15:0]  first_cksum = 16'h0000, last_len = 16'h0000, last_pay = 16'h0000;
    logic [63:0]  last_keep = 64'd0;
    logic         seen_any = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        frame_header_t h;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            after_last = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {axis.valid, axis.last, axis.keep, axis.data},
                    {1'b1, pl, pk, pd});
            end
            if (after_last && axis.valid) begin
                last_gap   = gapcnt;
                after_last = 1'b0;
            end else if (after_last) begin
                gapcnt++;
            end
            if (axis.valid && axis.ready) begin
                if (q.size() == 0) gen_frame();
                e = q.pop_front();
                chk("beat", {axis.last, axis.keep, axis.data}, {e.last, e.keep, e.data});
                if (e.first) begin
                    h = axis.data[271:0];
                    chk("ip_cksum_verify", 512'(fold_sum(axis.data[159:0])), 512'h0000FFFF);
                    last_len = h.total_len;
                    if (!seen_any) first_cksum = h.checksum;
                    seen_any = 1'b1;
                end else begin
                    last_pay = axis.data[15:0];
                end
                if (e.last) begin
                    last_keep  = axis.keep;
                    after_last = 1'b1;
                    gapcnt     = 0;
                    frames_run++;
                end
            end
            if (done && prev_done) chk("done_one_cycle", 512'(done), 512'd0);
            prev_done  = done;
            prev_stall = axis.valid && !axis.ready;
            pd = axis.data;
            pk = axis.keep;
            pl = axis.last;
        end
    end

    // Sink readiness: always ready, or random backpressure
    always @(posedge clk) begin
        #1;
        axis.ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_start(input logic [15:0] fs, input int cnt, input logic [15:0] gap,
                             input logic sw, input logic [15:0] step, input logic [15:0] mx);
        port_config.frame_size = fs;
        frame_count = cnt;
        gap_cycles  = gap;
        sweep_en    = sw;
        size_step   = step;
        size_max    = mx;
        m_min   = (fs < 16'd60) ? 16'd60 : fs;
        m_max   = (mx < 16'd60) ? 16'd60 : mx;
        m_size  = m_min;
        m_step  = step;
        m_sweep = sw;
        frames_run = 0;
        after_last = 1'b0;
        last_gap   = -1;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == budget) chk({name, "_timeout"}, 512'd0, 512'd1);
        cyc(1);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        sweep_en = 1'b0;
        frame_count = 32'd0;
        gap_cycles  = 16'd0;
        size_step   = 16'd0;
        size_max    = 16'd0;
        axis.ready  = 1'b1;
        port_config.dst_mac    = 48'h0200_0000_0002;
        port_config.src_mac    = 48'h0200_0000_0001;
        port_config.src_ip     = 32'h0A00_0001;
        port_config.dst_ip     = 32'h0A00_0002;
        port_config.frame_size = 16'd64;
        port_config.enable     = 1'b1;
        m_id = ID_SEED;

        #22;
        chk("rst_outputs", {axis.valid, axis.last, ready, done, axis.keep},
            {1'b0, 1'b0, 1'b0, 1'b0, 64'd0});
        chk("rst_data", axis.data, 512'd0);
        chk("rst_counters", {sent_frames, sent_bytes}, 64'd0);
        chk("lfsr_pin", 512'(tb_lfsr(16'hACE1)), 512'hE270);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("ready_idle", 512'(ready), 512'd1);

        // Fixed 64-byte frames, three back-to-back
        run_start(16'd64, 3, 16'd0, 1'b0, 16'd0, 16'd0);
        wait_done("t1", 100);
        chk("t1_frames", sent_frames, 512'd3);
        chk("t1_bytes", sent_bytes, 512'd192);
        chk("t1_model_frames", 512'(frames_run), 512'd3);
        chk("t1_first_cksum", 512'(first_cksum), 512'h0896);
        chk("t1_back_to_back", 512'(last_gap), 512'd0);
        chk("t1_keep", 512'(last_keep), 512'hFFFF_FFFF_FFFF_FFFF);

        // 100-byte frame: full beat then 36-byte tail
        run_start(16'd100, 1, 16'd0, 1'b0, 16'd0, 16'd0);
        wait_done("t2", 100);
        chk("t2_tail_keep", 512'(last_keep), 512'h0000_000F_FFFF_FFFF);
        chk("t2_ip_len", 512'(last_len), 512'd86);
        chk("t2_beat1_payload", 512'(last_pay), 512'hE270);
        chk("t2_bytes", sent_bytes, 512'd100);

        // Inter-frame gap of 5
        run_start(16'd64, 2, 16'd5, 1'b0, 16'd0, 16'd0);
        wait_done("t3", 100);
        chk("t3_gap", 512'(last_gap), 512'd5);
        chk("t3_frames", sent_frames, 512'd2);

        // Sweep 64..200 step 64: 64,128,192,64,128
        run_start(16'd64, 5, 16'd0, 1'b1, 16'd64, 16'd200);
        wait_done("t4", 200);
        chk("t4_bytes", sent_bytes, 512'd576);
        chk("t4_frames", sent_frames, 512'd5);

        // Small frame_size clamps to 60
        run_start(16'd20, 1, 16'd0, 1'b0, 16'd0, 16'd0);
        wait_done("t5", 100);
        chk("t5_clamp_bytes", sent_bytes, 512'd60);
        chk("t5_clamp_keep", 512'(last_keep), 512'h0FFF_FFFF_FFFF_FFFF);

        // Backpressure, unlimited run, stop mid-frame
        bp_en = 1'b1;
        run_start(16'd150, 0, 16'd0, 1'b0, 16'd0, 16'd0);
        guard = 0;
        while ((frames_run < 2 || q.size() == 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("t6_reach_mid", 512'(guard < 500), 512'd1);
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done("t6", 200);
        bp_en = 1'b0;
        chk("t6_no_partial", 512'(q.size()), 512'd0);
        chk("t6_frames", sent_frames, 512'(frames_run));
        chk("t6_bytes", sent_bytes, 512'(150 * frames_run));
        cyc(3);
        chk("t6_idle_valid", 512'(axis.valid), 512'd0);

        // Stop while in the gap
        run_start(16'd64, 0, 16'd20, 1'b0, 16'd0, 16'd0);
        guard = 0;
        while (frames_run < 1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done("t7", 5);
        chk("t7_frames", sent_frames, 512'd1);

        // Reset mid-frame
        run_start(16'd200, 0, 16'd0, 1'b0, 16'd0, 16'd0);
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_valid_async", 512'(axis.valid), 512'd0);
        q.delete();
        m_id = ID_SEED;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("t8_ready", 512'(ready), 512'd1);
        chk("t8_counters", {sent_frames, sent_bytes}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
